dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Controller and arbiter for the shared 64-bit data memory. Two requesters (port 0 = load/store unit,
//  port 1 = debug/DMA loader) issue single-word read/write requests over valid/ready. One winner is
//  granted at a time; the block drives the memory's read/write enables and address/data for exactly
//  one cycle, then returns a registered response. Out-of-range addresses are rejected without touching memory.
// PARAMETERS
//  ADDR_W     32        requester/memory address width (word address)
//  DATA_W     64        data word width
//  MEM_DEPTH  33554432  number of words; valid addresses are 0..MEM_DEPTH-1
// PORTS
//  clk          in   1        clock, all state updates on rising edge
//  reset        in   1        synchronous, active-high
//  req_valid    in   2        per-port request valid ([0]=LSU, [1]=DMA)
//  req_ready    out  2        per-port request accepted this cycle
//  req_we       in   2        per-port 1=write, 0=read
//  req_addr     in   2*ADDR_W per-port word address (port n at [n*ADDR_W +: ADDR_W])
//  req_wdata    in   2*DATA_W per-port write data
//  rsp_valid    out  2        one-cycle response pulse to the granted port
//  rsp_err      out  1        response carries out-of-range error (qualified by rsp_valid)
//  rsp_rdata    out  DATA_W   read data (qualified by rsp_valid, 0 for writes and errors)
//  mem_read_en  out  1        memory read enable
//  mem_write_en out  1        memory write enable
//  mem_addr1    out  ADDR_W   memory address port 1
//  mem_addr2    out  ADDR_W   memory address port 2 (driven equal to mem_addr1)
//  mem_wdata    out  DATA_W   memory write value
//  mem_val1     in   DATA_W   memory read data (combinational from memory)
// BEHAVIOUR
//  - FSM states IDLE, ISSUE, RESP. IDLE->ISSUE on any req_valid; ISSUE->RESP always; RESP->IDLE always.
//  - req_ready asserted only in IDLE, one-hot, for the arbitration winner; transfer = valid & ready.
//    Requesters hold valid/we/addr/wdata stable until ready; valid must not drop before transfer.
//  - On transfer, latch port id, we, addr, wdata, and oor = (addr >= MEM_DEPTH).
//  - ISSUE: if !oor, mem_read_en=!we, mem_write_en=we; both 0 if oor. mem_addr1/2=latched addr,
//    mem_wdata=latched wdata. Read data captured from mem_val1 at end of ISSUE.
//  - RESP: rsp_valid[port]=1 for one cycle; rsp_err=oor; rsp_rdata=captured data for non-oor reads, else 0.
//  - Latency: transfer cycle N -> memory access cycle N+1 -> rsp_valid cycle N+2. Throughput 1 per 3 cycles.
//  - Outside ISSUE: mem_read_en=mem_write_en=0, mem_addr1/2=0, mem_wdata=0.
//  - Simultaneous requests: arbitration per CONFIGURATION; loser keeps valid and wins next IDLE.
//  - Reset (any state): state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem enables=0,
//    addresses/wdata=0, RR pointer=port 0. An in-flight request is dropped with no response; a write
//    in ISSUE the same cycle reset is high is not performed (enables gated by !reset).
//  - req_ready is combinational from state, req_valid and priority pointer; not asserted while reset.
// CONFIGURATION
//  - DMEM_ARB_RR_EN defined: round-robin; after a port is granted, the other port has priority in
//    the next arbitration. Pointer updates only on transfer.
//  - DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins; port 1 can starve.
// STRUCTURE
//  - dmem_pkg: FSM state localparams (IDLE/ISSUE/RESP), port index constants, default ADDR_W/DATA_W/MEM_DEPTH.
//  - Sub-module dmem_rr_arb2: 2-way arbiter (req[1:0], ptr, grant[1:0]); macro selects RR or fixed.
//  - Top holds FSM, request latch, response registers and memory-side drive.
// TESTING
//  - Port0 write addr 5 data 64'hDEADBEEF, then port0 read addr 5 -> mem_write_en 1 cycle at N+1,
//    read rsp_valid[0] at N+2 with rsp_rdata=64'hDEADBEEF, rsp_err=0.
//  - Both ports read same cycle, RR_EN defined -> port0 granted first, port1 next; with ongoing requests
//    grants alternate 0,1,0,1. RR_EN undefined -> port0 held valid continuously wins every time.
//  - Port1 write addr MEM_DEPTH (33554432) -> no mem_write_en pulse, rsp_valid[1] with rsp_err=1, rdata=0;
//    subsequent read of addr 0 unaffected.
//  - Reset asserted during ISSUE of a write addr 7 data 64'h1 -> no write enable, no rsp_valid; later read
//    of addr 7 returns prior contents (0).
//  - Back-to-back requests on port0 -> req_ready asserted only every 3rd cycle; rsp_valid never overlaps
//    req_ready of the same transaction; mem_addr2 equals mem_addr1 whenever enables are high.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter slice.
//   - state_t and ST_* : arbiter FSM state encoding (IDLE/ISSUE/RESP)
//   - PORT_LSU/PORT_DMA: requester port indices
//   - DEF_*            : default address width, data width and memory depth
package dmem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

  localparam int PORT_LSU = 0;
  localparam int PORT_DMA = 1;

  localparam int          DEF_ADDR_W    = 32;
  localparam int          DEF_DATA_W    = 64;
  localparam int unsigned DEF_MEM_DEPTH = 32'd33554432;

endpackage

// File: rtl/dmem_rr_arb2.sv
// dmem_rr_arb2: two-way request arbiter.
// Build option: DMEM_ARB_RR_EN
//   defined   -> round-robin; ptr selects the port that wins a tie (0 = LSU, 1 = DMA)
//   undefined -> fixed priority, port 0 always wins; ptr is ignored
// Ports:
//   req   [1:0] in  : request vector ([0]=LSU, [1]=DMA)
//   ptr         in  : tie-break pointer, owned and updated by the caller
//   grant [1:0] out : one-hot winner, all-zero when nothing requests
module dmem_rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end
`else
  logic ptr_unused;
  assign ptr_unused = ptr;

  always_comb begin
    grant = 2'b00;
    if (req[PORT_LSU]) begin
      grant = 2'b01;
    end else if (req[PORT_DMA]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: controller/arbiter for the shared data memory.
// Two requesters issue single-word reads/writes; one is granted at a time,
// the memory is driven for exactly one cycle, then a registered response
// pulse returns to the granted port. Addresses >= MEM_DEPTH are rejected
// without enabling the memory.
// Build option: DMEM_ARB_RR_EN (round-robin when defined, else fixed priority
// with port 0 winning).
//
// Handshake: a request transfers in the cycle where req_valid[n] & req_ready[n]
// are both high at the rising edge. Requesters hold valid/we/addr/wdata stable
// until that transfer and never drop valid before it. req_ready is only ever
// high in IDLE, one-hot for the winner, and never while reset is high.
//
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   req_valid/ready/we [1:0] : per-port request handshake and direction
//   req_addr  [2*ADDR_W]     : port n address at [n*ADDR_W +: ADDR_W]
//   req_wdata [2*DATA_W]     : port n write data at [n*DATA_W +: DATA_W]
//   rsp_valid [1:0]          : one-cycle response pulse to the granted port
//   rsp_err, rsp_rdata       : out-of-range flag and read data (0 for writes/errors)
//   mem_read_en/write_en     : memory enables, high only during ISSUE
//   mem_addr1/2, mem_wdata   : memory address (both ports identical) and write data
//   mem_val1                 : combinational read data from memory
//   dbg_state                : current FSM state
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic [ADDR_W-1:0]   mem_addr1,
  output logic [ADDR_W-1:0]   mem_addr2,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_val1,
  output state_t              dbg_state
);

  // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          grant;
  logic                rr_ptr;
  logic [1:0]          xfer;
  logic                win_port;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_we;
  logic                issue_act;

  logic                lat_port;
  logic                lat_we;
  logic                lat_oor;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  dmem_rr_arb2 u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign xfer      = req_valid & req_ready;
  assign win_port  = grant[PORT_DMA];
  assign win_addr  = win_port ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
  assign win_wdata = win_port ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
  assign win_we    = win_port ? req_we[PORT_DMA] : req_we[PORT_LSU];
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; in IDLE any valid request is granted, so it always transfers.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|req_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. Everything memory-facing is gated by !reset so a write
  // sitting in ISSUE when reset arrives never reaches the memory.
  always_comb begin
    req_ready    = 2'b00;
    issue_act    = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr1    = '0;
    mem_addr2    = '0;
    mem_wdata    = '0;
    if (!reset) begin
      if (state == ST_IDLE) begin
        req_ready = grant;
      end
      if (state == ST_ISSUE) begin
        issue_act    = 1'b1;
        mem_read_en  = !lat_oor && !lat_we;
        mem_write_en = !lat_oor && lat_we;
        mem_addr1    = lat_addr;
        mem_addr2    = lat_addr;
        mem_wdata    = lat_wdata;
      end
    end
  end

  // Request latch and tie-break pointer; the pointer hands priority to the
  // port that was not just served, and only moves on a real transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_oor   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rr_ptr    <= 1'b0;
    end else if (|xfer) begin
      lat_port  <= win_port;
      lat_we    <= win_we;
      lat_oor   <= ({1'b0, win_addr} >= DEPTH_EXT);
      lat_addr  <= win_addr;
      lat_wdata <= win_wdata;
      rr_ptr    <= grant[PORT_LSU];
    end
  end

  // Response registers: loaded at the end of ISSUE (read data captured from
  // mem_val1 there), visible during RESP, cleared otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 2'b00;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (issue_act) begin
      rsp_valid <= lat_port ? 2'b10 : 2'b01;
      rsp_err   <= lat_oor;
      rsp_rdata <= (!lat_oor && !lat_we) ? mem_val1 : '0;
    end else begin
      rsp_valid <= 2'b00;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter.
// A small word memory is attached to the memory side. A transaction-level
// reference model (grant rule, fixed 1-cycle access / 2-cycle response
// latency, associative-array memory image) predicts every cycle's outputs.
// Honours DMEM_ARB_RR_EN the same way the design does.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int          AW    = 32;
  localparam int          DW    = 64;
  localparam logic [31:0] DEPTH = 32'(DEF_MEM_DEPTH);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [AW-1:0] mem_addr1;
  logic [AW-1:0] mem_addr2;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_val1;
  state_t        dbg_state;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEF_MEM_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_wdata(mem_wdata), .mem_val1(mem_val1),
    .dbg_state(dbg_state)
  );

  // Attached memory: 32 words; the bench only uses addresses whose low
  // five bits are distinct among the in-range ones (0..15 and DEPTH-1).
  logic [DW-1:0] mem_arr [0:31] = '{default: 64'h0};
  assign mem_val1 = mem_arr[mem_addr1[4:0]];
  always @(posedge clk) begin
    if (mem_write_en) mem_arr[mem_addr1[4:0]] <= mem_wdata;
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    logic        v;
    int          port;
    logic        we;
    logic        oor;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } txn_t;

  req_t q0[$];
  req_t q1[$];

  // reference model state
  logic [63:0] ref_mem [logic [31:0]];
  txn_t        m_acc;
  txn_t        m_rsp;
  int          m_busy;
  int          m_prio;

  // observation logs
  logic [1:0]  exp_q[$];
  logic [1:0]  got_q[$];
  logic [64:0] rsp_q[$];
  int          wr_pulses;
  bit          rand_on;
  bit          rst_on_issue;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  function automatic logic [63:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'h0;
  endfunction

  function automatic req_t mk(input logic we, input logic [31:0] a, input logic [63:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    return r;
  endfunction

  function automatic req_t rand_req();
    int unsigned sel;
    logic [31:0] a;
    sel = $urandom_range(0, 19);
    if (sel < 16)       a = sel;
    else if (sel == 16) a = DEPTH - 1;
    else if (sel == 17) a = DEPTH;
    else if (sel == 18) a = DEPTH + 3;
    else                a = 32'hFFFF_FFFF;
    return mk(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
  endfunction

  function automatic txn_t idle_txn();
    txn_t t;
    t.v = 1'b0; t.port = 0; t.we = 1'b0; t.oor = 1'b0;
    t.addr = '0; t.wdata = '0; t.rdata = '0;
    return t;
  endfunction

  // ---------------- driver ----------------
  task automatic drive();
    req_valid = {q1.size() != 0, q0.size() != 0};
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    if (q0.size() != 0) begin
      req_we[0] = q0[0].we; req_addr[31:0] = q0[0].addr; req_wdata[63:0] = q0[0].wdata;
    end
    if (q1.size() != 0) begin
      req_we[1] = q1[0].we; req_addr[63:32] = q1[0].addr; req_wdata[127:64] = q1[0].wdata;
    end
  endtask

  // One clock: check at the falling edge, advance the model for the rising
  // edge, then drive the next cycle's inputs 1 time unit after it.
  task automatic step();
    logic [1:0]  exp_rdy;
    logic [1:0]  obs_x;
    int          w;
    logic        e_re, e_we;
    logic [31:0] e_addr;
    logic [63:0] e_wd;
    @(negedge clk);
    exp_rdy = 2'b00;
    w = 0;
    if (!reset && m_busy == 0 && req_valid != 2'b00) begin
`ifdef DMEM_ARB_RR_EN
      if (req_valid == 2'b11) w = m_prio;
      else                    w = req_valid[0] ? 0 : 1;
`else
      w = req_valid[0] ? 0 : 1;
`endif
      exp_rdy = (w == 0) ? 2'b01 : 2'b10;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));

    e_re = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (m_acc.v && !reset) begin
      e_addr = m_acc.addr;
      e_wd   = m_acc.wdata;
      e_re   = !m_acc.oor && !m_acc.we;
      e_we   = !m_acc.oor && m_acc.we;
    end
    chk("mem_read_en",  64'(mem_read_en),  64'(e_re));
    chk("mem_write_en", 64'(mem_write_en), 64'(e_we));
    chk("mem_addr1",    64'(mem_addr1),    64'(e_addr));
    chk("mem_addr2",    64'(mem_addr2),    64'(e_addr));
    chk("mem_wdata",    mem_wdata,         e_wd);

    chk("rsp_valid", 64'(rsp_valid), m_rsp.v ? ((m_rsp.port == 0) ? 64'd1 : 64'd2) : 64'd0);
    chk("rsp_err",   64'(rsp_err),   m_rsp.v ? 64'(m_rsp.oor) : 64'd0);
    chk("rsp_rdata", rsp_rdata,      m_rsp.v ? m_rsp.rdata : 64'd0);

    if (req_ready == 2'b01) got_q.push_back(2'd0);
    else if (req_ready == 2'b10) got_q.push_back(2'd1);
    if (rsp_valid != 2'b00) rsp_q.push_back({rsp_err, rsp_rdata});
    if (mem_write_en === 1'b1) wr_pulses++;

    obs_x = req_valid & req_ready;
    if (obs_x[0] === 1'b1 && q0.size() != 0) void'(q0.pop_front());
    if (obs_x[1] === 1'b1 && q1.size() != 0) void'(q1.pop_front());

    // model advance: access completes, new transfer is latched
    if (reset) begin
      m_acc  = idle_txn();
      m_rsp  = idle_txn();
      m_busy = 0;
      m_prio = 0;
    end else begin
      m_rsp = m_acc;
      if (m_acc.v) begin
        if (!m_acc.oor && m_acc.we) ref_mem[m_acc.addr] = m_acc.wdata;
        m_rsp.rdata = (!m_acc.oor && !m_acc.we) ? ref_rd(m_acc.addr) : 64'h0;
      end
      if (exp_rdy != 2'b00) begin
        m_acc.v     = 1'b1;
        m_acc.port  = w;
        m_acc.we    = req_we[w];
        m_acc.addr  = req_addr[w*AW +: AW];
        m_acc.wdata = req_wdata[w*DW +: DW];
        m_acc.oor   = (req_addr[w*AW +: AW] >= DEPTH);
        m_acc.rdata = '0;
        m_busy      = 2;
        m_prio      = 1 - w;
      end else begin
        m_acc = idle_txn();
        if (m_busy > 0) m_busy--;
      end
    end

    @(posedge clk);
    #1;
    if (rst_on_issue && m_acc.v) begin
      reset = 1'b1;
      rst_on_issue = 1'b0;
    end else begin
      reset = 1'b0;
    end
    if (rand_on) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
    end
    drive();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_busy != 0 || m_acc.v || m_rsp.v) && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_done_in_budget"}, 64'(n < 300), 64'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    m_acc = idle_txn();
    m_rsp = idle_txn();
    m_busy = 0; m_prio = 0;
    wr_pulses = 0; rand_on = 1'b0; rst_on_issue = 1'b0;

    // reset, with a request already pending: ready must stay low
    reset = 1'b1;
    req_valid = 2'b01; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    chk("rst_rsp_rdata", rsp_rdata,      64'd0);
    chk("rst_mem_en",    64'({mem_read_en, mem_write_en}), 64'd0);
    chk("rst_mem_addr",  64'(mem_addr1), 64'd0);
    chk("rst_state",     64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive();

    // arbitration: both ports request together, two reads each
    q0.push_back(mk(1'b0, 32'd1, 64'h0)); q0.push_back(mk(1'b0, 32'd2, 64'h0));
    q1.push_back(mk(1'b0, 32'd3, 64'h0)); q1.push_back(mk(1'b0, 32'd4, 64'h0));
    drive();
    got_q.delete();
`ifdef DMEM_ARB_RR_EN
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_q = '{2'd0, 2'd0, 2'd1, 2'd1};
`endif
    drain("arb");
    chk("arb_grant_count", 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      chk("arb_grant_order", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    end

    // write 5 then read it back on port 0
    wr_pulses = 0; rsp_q.delete();
    q0.push_back(mk(1'b1, 32'd5, 64'hDEAD_BEEF));
    q0.push_back(mk(1'b0, 32'd5, 64'h0));
    drive();
    drain("wr_rd5");
    chk("wr5_pulses", 64'(wr_pulses), 64'd1);
    chk("rd5_rsp_count", 64'(rsp_q.size()), 64'd2);
    if (rsp_q.size() == 2) chk("rd5_rdata", 64'(rsp_q[1]), 64'hDEAD_BEEF);

    // out-of-range write on port 1, then a normal read of address 0
    wr_pulses = 0; rsp_q.delete();
    q1.push_back(mk(1'b1, DEPTH, 64'h1234_5678_9ABC_DEF0));
    q1.push_back(mk(1'b0, 32'd0, 64'h0));
    drive();
    drain("oor");
    chk("oor_pulses", 64'(wr_pulses), 64'd0);
    chk("oor_rsp_count", 64'(rsp_q.size()), 64'd2);
    if (rsp_q.size() == 2) begin
      chk("oor_err",   64'(rsp_q[0][64]), 64'd1);
      chk("oor_rdata", rsp_q[0][63:0],    64'd0);
      chk("rd0_err",   64'(rsp_q[1][64]), 64'd0);
    end

    // reset lands in ISSUE of a write to 7: nothing written, no response
    wr_pulses = 0; rsp_q.delete();
    q0.push_back(mk(1'b1, 32'd7, 64'h1));
    rst_on_issue = 1'b1;
    drive();
    drain("rst_issue");
    chk("rst_issue_pulses", 64'(wr_pulses), 64'd0);
    chk("rst_issue_rsp",    64'(rsp_q.size()), 64'd0);
    q0.push_back(mk(1'b0, 32'd7, 64'h0));
    drive();
    drain("rd7");
    chk("rd7_rsp_count", 64'(rsp_q.size()), 64'd1);
    if (rsp_q.size() == 1) chk("rd7_rdata", 64'(rsp_q[0]), 64'd0);

    // randomized traffic on both ports
    rand_on = 1'b1;
    repeat (400) step();
    rand_on = 1'b0;
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
